// File: rtl/mem_access_unit_if.sv
// Data-cache request bus between the memory-stage unit and the dcache.
// Handshake: the unit holds dmemREN/dmemWEN (with dmemaddr/dmemstore) high
// until the cache answers with a one-cycle dhit; dmemload is valid only in
// that dhit cycle. There is no back-pressure other than withholding dhit.
interface mem_access_unit_if #(
   parameter int DATA_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [DATA_W-1:0] dmemaddr;
   logic [DATA_W-1:0] dmemstore;
   logic              dhit;
   logic [DATA_W-1:0] dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns the latched EX/MEM memory controls into a
// dcache request, waits for dhit, holds load/SC data until the pipeline
// advances, owns the LL/SC link register, the sticky halt flag and a stall
// watchdog.
module mem_access_unit #(
   parameter int DATA_W   = 32,
   parameter int WATCHDOG = 0
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic [4:0]        MEMctrl,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] store,
   input  logic              snoop_inv,
   input  logic [DATA_W-1:0] snoop_addr,
   mem_access_unit_if.master dcif,
   output logic              mem_stall,
   output logic [DATA_W-1:0] wb_data,
   output logic              halt,
   output logic              mem_err,
   output logic              state_dbg
);

   typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

   localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam int                WD_W  = (WATCHDOG > 0) ? $clog2(WATCHDOG + 1) : 1;
   localparam logic [WD_W-1:0]   WD_MAX = WD_W'(WATCHDOG);

   state_t            state;
   logic [DATA_W-1:0] held_data;
   logic [DATA_W-1:0] link_addr;
   logic              link_valid;
   logic [WD_W-1:0]   wd_cnt;

   logic ren, wen, ll, sc, hlt;
   logic sc_ok, op, complete, ll_done, link_clr;

   assign ren = MEMctrl[0];
   assign wen = MEMctrl[1];
   assign ll  = MEMctrl[2];
   assign sc  = MEMctrl[3];
   assign hlt = MEMctrl[4];

   assign sc_ok     = link_valid && (link_addr == aluout);
   assign state_dbg = state;

   // Request decode and output mux; everything forced low while in reset.
   always_comb begin
      op             = 1'b0;
      dcif.dmemREN   = 1'b0;
      dcif.dmemWEN   = 1'b0;
      dcif.dmemaddr  = '0;
      dcif.dmemstore = '0;
      mem_stall      = 1'b0;
      wb_data        = '0;
      if (nRST) begin
         dcif.dmemaddr  = aluout;
         dcif.dmemstore = store;
         if (state == IDLE) begin
            op           = ren | wen | ll | (sc & sc_ok);
            dcif.dmemREN = ren | ll;
            dcif.dmemWEN = wen | (sc & sc_ok);
            mem_stall    = op & ~dcif.dhit;
            if (op && dcif.dhit)
               wb_data = (sc && sc_ok) ? ONE_W : dcif.dmemload;
         end else begin
            wb_data = held_data;
         end
      end
   end

   // A failing SC never reaches the cache, so it drops the link immediately.
   assign complete = (state == IDLE) && op && dcif.dhit;
   assign ll_done  = complete && ll;
   assign link_clr = (snoop_inv && (snoop_addr == link_addr))
                  || (complete && wen && (aluout == link_addr))
                  || (complete && sc && sc_ok)
                  || ((state == IDLE) && sc && !sc_ok);

   // FSM plus link register, sticky flags and watchdog counter.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         held_data  <= '0;
         link_valid <= 1'b0;
         link_addr  <= '0;
         halt       <= 1'b0;
         mem_err    <= 1'b0;
         wd_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (complete && !ihit) begin
                  state     <= DONE;
                  held_data <= (sc && sc_ok) ? ONE_W : dcif.dmemload;
               end
            end
            DONE: begin
               if (ihit)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // LL is the newer event, so it beats a same-cycle clear.
         if (ll_done) begin
            link_valid <= 1'b1;
            link_addr  <= aluout;
         end else if (link_clr) begin
            link_valid <= 1'b0;
         end

         if (hlt && ihit && !mem_stall)
            halt <= 1'b1;

         if (WATCHDOG > 0) begin
            if (mem_stall) begin
               if (wd_cnt == WD_MAX)
                  mem_err <= 1'b1;
               else
                  wd_cnt <= wd_cnt + 1'b1;
            end else begin
               wd_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed memory-stage ops with hand-computed
// writeback values, plus link, halt, watchdog and reset behaviour.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0;
   logic [4:0]  MEMctrl = '0;
   logic [31:0] aluout = '0;
   logic [31:0] store = '0;
   logic        snoop_inv = 1'b0;
   logic [31:0] snoop_addr = '0;
   logic        mem_stall;
   logic [31:0] wb_data;
   logic        halt;
   logic        mem_err;
   logic        state_dbg;

   logic        tb_valid = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   int          checks = 0;
   int          errors = 0;

   localparam logic [4:0] C_REN = 5'b00001;
   localparam logic [4:0] C_WEN = 5'b00010;
   localparam logic [4:0] C_LL  = 5'b00100;
   localparam logic [4:0] C_SC  = 5'b01000;
   localparam logic [4:0] C_HLT = 5'b10000;

   mem_access_unit_if #(.DATA_W(32)) dcif ();

   mem_access_unit #(.DATA_W(32), .WATCHDOG(4)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .ihit       (ihit),
      .MEMctrl    (MEMctrl),
      .aluout     (aluout),
      .store      (store),
      .snoop_inv  (snoop_inv),
      .snoop_addr (snoop_addr),
      .dcif       (dcif.master),
      .mem_stall  (mem_stall),
      .wb_data    (wb_data),
      .halt       (halt),
      .mem_err    (mem_err),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   initial begin
      dcif.dhit     = 1'b0;
      dcif.dmemload = '0;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // monitor: pop one expected writeback each time the pipeline advances
   always @(negedge CLK) begin
      if (nRST && tb_valid && ihit && !mem_stall) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got %h want none", wb_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (wb_data !== mon_exp) begin
               errors++;
               $display("FAIL wb_data: got %h want %h", wb_data, mon_exp);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // driver: one memory-stage op. req=1 means a cache request is expected;
   // dly stall cycles precede dhit, idly cycles of ihit=0 follow dhit.
   task automatic run_op(input string nm, input logic [4:0] ctrl,
                         input logic [31:0] a, input logic [31:0] st,
                         input logic [31:0] ld, input logic [31:0] exp_wb,
                         input bit req, input logic exp_ren, input logic exp_wen,
                         input int dly, input int idly);
      int stalls;
      stalls = 0;
      exp_q.push_back(exp_wb);
      MEMctrl = ctrl; aluout = a; store = st; tb_valid = 1'b1;
      if (req) begin
         for (int i = 0; i < dly; i++) begin
            dcif.dhit = 1'b0; ihit = 1'b1;
            @(negedge CLK);
            if (mem_stall) stalls++;
            next_cycle();
         end
         dcif.dhit = 1'b1; dcif.dmemload = ld; ihit = (idly == 0);
         @(negedge CLK);
         check({nm, " ren"},   {31'd0, dcif.dmemREN}, {31'd0, exp_ren});
         check({nm, " wen"},   {31'd0, dcif.dmemWEN}, {31'd0, exp_wen});
         check({nm, " addr"},  dcif.dmemaddr, a);
         check({nm, " store"}, dcif.dmemstore, st);
         if (mem_stall) stalls++;
         next_cycle();
         dcif.dhit = 1'b0; dcif.dmemload = 32'hBAD0_BAD0;
         for (int i = 0; i < idly; i++) begin
            ihit = (i == idly - 1);
            @(negedge CLK);
            check({nm, " done_req"}, {30'd0, dcif.dmemREN, dcif.dmemWEN}, 32'd0);
            check({nm, " done_wb"}, wb_data, exp_wb);
            next_cycle();
         end
         check({nm, " stall_cycles"}, stalls, dly);
      end else begin
         dcif.dhit = 1'b0; ihit = 1'b1;
         @(negedge CLK);
         check({nm, " noreq"}, {29'd0, dcif.dmemREN, dcif.dmemWEN, mem_stall}, 32'd0);
         next_cycle();
      end
      MEMctrl = '0; tb_valid = 1'b0; ihit = 1'b1;
   endtask

   task automatic snoop(input logic [31:0] a);
      snoop_inv = 1'b1; snoop_addr = a;
      next_cycle();
      snoop_inv = 1'b0;
   endtask

   initial begin
      // reset state, with a load already presented
      MEMctrl = C_REN; aluout = 32'h40; store = 32'h11;
      @(negedge CLK);
      check("rst req", {30'd0, dcif.dmemREN, dcif.dmemWEN}, 32'd0);
      check("rst stall", {31'd0, mem_stall}, 32'd0);
      check("rst addr", dcif.dmemaddr, 32'd0);
      check("rst wb", wb_data, 32'd0);
      check("rst flags", {29'd0, halt, mem_err, state_dbg}, 32'd0);
      MEMctrl = '0;
      next_cycle();
      nRST = 1'b1; ihit = 1'b1;
      next_cycle();

      // loads: bypass and held-in-DONE
      run_op("lw_bypass", C_REN, 32'h40, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 0, 3, 0);
      run_op("lw_held",   C_REN, 32'h44, 32'h0, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 1, 2);
      run_op("sw",        C_WEN, 32'h80, 32'hCAFE, 32'h0, 32'h0, 1, 0, 1, 1, 0);

      // LL/SC success then repeated SC fails
      run_op("ll1",  C_LL, 32'h100, 32'h0, 32'hAAAA_0001, 32'hAAAA_0001, 1, 1, 0, 1, 0);
      run_op("sc1",  C_SC, 32'h100, 32'h7, 32'h0, 32'h1, 1, 0, 1, 2, 0);
      run_op("sc1r", C_SC, 32'h100, 32'h7, 32'h0, 32'h0, 0, 0, 0, 0, 0);

      // snoop to the linked address kills the link
      run_op("ll2", C_LL, 32'h100, 32'h0, 32'h5, 32'h5, 1, 1, 0, 0, 0);
      snoop(32'h100);
      run_op("sc2", C_SC, 32'h100, 32'h9, 32'h0, 32'h0, 0, 0, 0, 0, 0);

      // unrelated snoop keeps the link; SC result held while ihit low
      run_op("ll3", C_LL, 32'h200, 32'h0, 32'h6, 32'h6, 1, 1, 0, 0, 0);
      snoop(32'h300);
      run_op("sc3", C_SC, 32'h200, 32'h9, 32'h0, 32'h1, 1, 0, 1, 0, 1);

      // local store to the linked address kills the link
      run_op("ll4", C_LL, 32'h100, 32'h0, 32'h8, 32'h8, 1, 1, 0, 0, 0);
      run_op("sw4", C_WEN, 32'h100, 32'h3, 32'h0, 32'h0, 1, 0, 1, 0, 0);
      run_op("sc4", C_SC, 32'h100, 32'h9, 32'h0, 32'h0, 0, 0, 0, 0, 0);

      // non-memory op
      run_op("nop", 5'b00000, 32'h44, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

      // halt is sticky
      check("halt pre", {31'd0, halt}, 32'd0);
      run_op("halt", C_HLT, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
      check("halt set", {31'd0, halt}, 32'd1);
      repeat (3) next_cycle();
      check("halt hold", {31'd0, halt}, 32'd1);

      // watchdog: link set, then a load that never gets dhit
      run_op("ll5", C_LL, 32'h300, 32'h0, 32'h2, 32'h2, 1, 1, 0, 0, 0);
      MEMctrl = C_REN; aluout = 32'h500; ihit = 1'b1; dcif.dhit = 1'b0;
      repeat (4) next_cycle();
      check("wd after4", {31'd0, mem_err}, 32'd0);
      next_cycle();
      check("wd after5", {31'd0, mem_err}, 32'd1);
      check("wd req held", {31'd0, dcif.dmemREN}, 32'd1);

      // asynchronous reset mid-request
      nRST = 1'b0;
      #1;
      check("rst2 req", {29'd0, dcif.dmemREN, dcif.dmemWEN, mem_stall}, 32'd0);
      check("rst2 bus", dcif.dmemaddr | wb_data, 32'd0);
      check("rst2 flags", {29'd0, halt, mem_err, state_dbg}, 32'd0);
      MEMctrl = '0;
      next_cycle();
      nRST = 1'b1;
      next_cycle();

      // link was cleared by reset
      run_op("sc6", C_SC, 32'h300, 32'h9, 32'h0, 32'h0, 0, 0, 0, 0, 0);
      next_cycle();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL exp_q_left: got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
